// File: rtl/imem_fetch_responder_pkg.sv
// Shared types and constants for the instruction-memory fetch responder.
package common;

    typedef logic [31:0] instruction_type;

    typedef enum logic [2:0] {
        IDLE,
        RESP,
        SPLIT_LO,
        SPLIT_HI,
        FAULT
    } imem_state_t;

    localparam instruction_type IMEM_NOP = 32'h0000_0013;

endpackage

// File: rtl/imem_fetch_responder_if.sv
// Fetch/load port bundle between the fetch stage (master) and the instruction memory (slave).
interface imem_fetch_responder_if;
    import common::*;

    logic            fetch_req;
    logic [31:0]     fetch_addr;
    instruction_type fetch_data;
    logic            fetch_valid;
    logic            fetch_fault;
    logic            fetch_busy;
    logic            load_we;
    logic [31:0]     load_addr;
    logic [31:0]     load_data;

    modport master (
        output fetch_req, fetch_addr, load_we, load_addr, load_data,
        input  fetch_data, fetch_valid, fetch_fault, fetch_busy
    );

    modport slave (
        input  fetch_req, fetch_addr, load_we, load_addr, load_data,
        output fetch_data, fetch_valid, fetch_fault, fetch_busy
    );
endinterface

// File: rtl/imem_fetch_responder_ram.sv
// Word RAM with one synchronous read port (read-first) and an independent write port.
module imem_ram_1r1w #(
    parameter int DEPTH_WORDS = 1024,
    parameter     INIT_FILE   = "",
    localparam int IW         = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          re,
    input  logic [IW-1:0] raddr,
    output logic [31:0]   rdata,
    input  logic          we,
    input  logic [IW-1:0] waddr,
    input  logic [31:0]   wdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // NOTE: the array has no reset branch; resetting a RAM would force it into
    // flops. Both updates use <= so a same-cycle read sees the old word.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/imem_fetch_responder.sv
// Fetch responder: FSM, split-read halfword latch and response registers.
// Build with IMEM_MISALIGN_EN defined to serve halfword-aligned fetches as two-beat split reads.
module imem_fetch_responder
    import common::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter     INIT_FILE   = ""
) (
    input  logic                   clk,
    input  logic                   reset_n,
    imem_fetch_responder_if.slave  bus
);

    localparam int IW = $clog2(DEPTH_WORDS);
    typedef logic [IW-1:0] word_idx_t;

    imem_state_t     state, state_next;
    logic            accept;
    word_idx_t       fetch_idx;
    logic            ram_re;
    word_idx_t       ram_raddr;
    logic [31:0]     ram_rdata;
    logic            valid_q, fault_q;
    instruction_type data_q, resp_data;
    logic            unused_addr_bits;

`ifdef IMEM_MISALIGN_EN
    word_idx_t       split_idx_q;
    logic [15:0]     w0_q;
`endif

    assign fetch_idx        = bus.fetch_addr[2+IW-1:2];
    assign bus.fetch_busy   = (state != IDLE) || bus.load_we;
    assign accept           = bus.fetch_req && !bus.fetch_busy;
    assign unused_addr_bits = ^{bus.fetch_addr[31:2+IW], bus.load_addr[31:2+IW], bus.load_addr[1:0]};

    imem_ram_1r1w #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .INIT_FILE   (INIT_FILE)
    ) u_ram (
        .clk   (clk),
        .re    (ram_re),
        .raddr (ram_raddr),
        .rdata (ram_rdata),
        .we    (bus.load_we),
        .waddr (bus.load_addr[2+IW-1:2]),
        .wdata (bus.load_data)
    );

    // NOTE: every output of this block gets a default first so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        ram_re     = 1'b0;
        ram_raddr  = fetch_idx;
        case (state)
            IDLE: begin
                if (accept) begin
                    case (bus.fetch_addr[1:0])
                        2'b00: begin
                            state_next = RESP;
                            ram_re     = 1'b1;
                        end
`ifdef IMEM_MISALIGN_EN
                        2'b10: begin
                            state_next = SPLIT_LO;
                            ram_re     = 1'b1;
                        end
`endif
                        default: state_next = FAULT;
                    endcase
                end
            end
            RESP:     state_next = IDLE;
            FAULT:    state_next = IDLE;
`ifdef IMEM_MISALIGN_EN
            // The index increment wraps naturally at the IW-bit width.
            SPLIT_LO: begin
                state_next = SPLIT_HI;
                ram_re     = 1'b1;
                ram_raddr  = split_idx_q + word_idx_t'(1);
            end
            SPLIT_HI: state_next = IDLE;
`endif
            default:  state_next = IDLE;
        endcase
    end

    always_comb begin
        resp_data = data_q;
        case (state)
            RESP:     resp_data = ram_rdata;
            FAULT:    resp_data = IMEM_NOP;
`ifdef IMEM_MISALIGN_EN
            SPLIT_HI: resp_data = {ram_rdata[15:0], w0_q};
`endif
            default:  resp_data = data_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= IDLE;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
            data_q  <= '0;
        end else begin
            state   <= state_next;
            valid_q <= (state_next == RESP) || (state_next == FAULT) || (state_next == SPLIT_HI);
            fault_q <= (state_next == FAULT);
            data_q  <= resp_data;
        end
    end

`ifdef IMEM_MISALIGN_EN
    // Split bookkeeping is pure datapath and only consumed under FSM control.
    always_ff @(posedge clk) begin
        if (accept) begin
            split_idx_q <= fetch_idx;
        end
        if (state == SPLIT_LO) begin
            w0_q <= ram_rdata[31:16];
        end
    end
`endif

    assign bus.fetch_data  = resp_data;
    assign bus.fetch_valid = valid_q;
    assign bus.fetch_fault = fault_q;

endmodule
